multi_cycle_cu: RTL and testbench
=================================

Name: multi_cycle_cu

Overview:
- Multi-cycle control unit sequencing the existing single-cycle datapath (PC, instruction memory, register file, ALU, data memory, write-back mux) through IF/ID/EXE/MEM/WB phases.
- Replaces the combinational control unit. Outputs the same control-signal set plus IRWre, a 2-bit PCSrc, a halt flag and a retired-instruction counter.
- Waits on a data-memory ready handshake in MEM.

Parameters:
- CNT_W, 32, width of retired-instruction counter InsCount.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- op  in  6  opcode from instruction memory output (instruction[31:26]).
- zero  in  1  ALU zero flag.
- MemReady  in  1  data memory completes access this cycle.
- PCWre  out  1  PC write enable (one pulse per retired instruction).
- IRWre  out  1  latch instruction/opcode.
- InsMenRW  out  1  instruction memory read (1 = read).
- ExtSel  out  1  0 = zero-extend, 1 = sign-extend.
- ALUSrcB  out  1  0 = readData2, 1 = extendOut.
- ALUOp  out  3  ALU function.
- RegOut  out  1  destination register: 0 = rt, 1 = rd.
- RegWre  out  1  register file write enable.
- ALUM2Reg  out  1  write-back source: 0 = ALU result, 1 = dataOut.
- DataMenRW  out  1  data memory: 0 = read, 1 = write.
- PCSrc  out  2  next PC: 00 = PC+4, 01 = branch target, 11 = jump.
- Halted  out  1  HALT executed; sticky until reset.
- State  out  4  current FSM state (debug).
- InsCount  out  CNT_W  retired-instruction count.

Behaviour:
- Opcodes:
  - ADD 000000, SUB 000001, ADDI 000010
  - OR 010000, AND 010001, ORI 010010
  - SW 100110, LW 100111
  - BEQ 110000, J 111000, HALT 111111
  - Any other opcode is a NOP.
- States (4-bit): IF=0, ID=1, EXE_AL=2, WB_AL=3, EXE_BR=4, EXE_LS=5, MEM=6, WB_LD=7, HALT=8.
- op_q register: loads op on the rising edge that leaves IF (IRWre high). All decode uses op_q; op is ignored outside IF.
- Transitions:
  - IF -> ID.
  - ID -> EXE_AL for ADD/SUB/ADDI/OR/AND/ORI.
  - ID -> EXE_BR for BEQ; ID -> EXE_LS for LW/SW.
  - ID -> IF for J or NOP; ID -> HALT for HALT.
  - EXE_AL -> WB_AL -> IF.
  - EXE_BR -> IF.
  - EXE_LS -> MEM.
  - MEM holds while MemReady=0. When MemReady=1: SW -> IF, LW -> WB_LD.
  - WB_LD -> IF.
  - HALT is absorbing.
- Outputs are combinational from (State, op_q, zero, MemReady). Every signal not listed below is 0.
  - IF: IRWre=1, InsMenRW=1.
  - ID, J: PCWre=1, PCSrc=11.
  - ID, NOP: PCWre=1, PCSrc=00.
- Stable op_q-only decode, driven in every state from ID onward:
  - ALUOp: 000 for ADD/ADDI/LW/SW, 001 for SUB/BEQ, 011 for OR/ORI, 100 for AND.
  - ALUSrcB=1 for ADDI/ORI/LW/SW.
  - ExtSel=0 for ORI, 1 otherwise.
  - RegOut=1 for ADD/SUB/OR/AND.
- Per-state pulses:
  - EXE_BR: PCWre=1, PCSrc = zero ? 01 : 00.
  - WB_AL: RegWre=1, ALUM2Reg=0, PCWre=1, PCSrc=00.
  - MEM: DataMenRW=1 when op_q=SW (held throughout the wait). PCWre = MemReady & SW.
  - WB_LD: RegWre=1, ALUM2Reg=1, PCWre=1.
- Halt: Halted register sets on entering HALT. HALT emits no PCWre and no RegWre.
- InsCount increments on every cycle with PCWre=1 and wraps at 2^CNT_W.
- Latency in cycles: J/NOP 2, BEQ 3, ALU-type 4, SW 4+w, LW 5+w, where w = MemReady-low cycles.
- Reset (asynchronous, any state, including mid-MEM wait):
  - State=IF, op_q=0, Halted=0, InsCount=0.
  - Outputs then show IF values: IRWre=1, InsMenRW=1, all others 0.
  - Release resumes at IF.
- Outside IF, IRWre=0 regardless of op changes.

Decomposition:
- Package multi_cycle_pkg holds opcode constants, state encodings, ALUOp codes and PCSrc codes.
- One combinational sub-module, multi_cycle_decode, maps (State, op_q, zero, MemReady) to the control outputs. The FSM, op_q, Halted and InsCount live in the top.

Test Plan:
- Reset low mid-EXE_AL -> State=0, IRWre=1, InsCount=0, Halted=0 immediately; after release, IF->ID on the next edge.
- ADD (op=000000) -> States 0,1,2,3,0.
  - WB_AL: RegWre=1, RegOut=1, ALUOp=000, PCWre=1, PCSrc=00.
  - InsCount 0->1.
- BEQ with zero=1 -> EXE_BR shows PCSrc=01, PCWre=1, ALUOp=001. Repeat with zero=0 -> PCSrc=00. Total 3 cycles each.
- LW with MemReady low 3 cycles -> MEM held 3 cycles with DataMenRW=0, PCWre=0; then WB_LD: RegWre=1, ALUM2Reg=1, RegOut=0, PCWre=1. 8 cycles total.
- SW -> in MEM, DataMenRW=1, ALUSrcB=1, ExtSel=1; PCWre only in the MemReady=1 cycle; RegWre never asserted.
- J, then ORI, then HALT:
  - J: PCSrc=11 in ID.
  - ORI: ExtSel=0, ALUOp=011, RegOut=0.
  - HALT: State=8, Halted=1, InsCount=2 and frozen over 20 further cycles.

Source files
------------

// File: rtl/multi_cycle_cu_pkg.sv
// multi_cycle_pkg: shared constants for the multi-cycle control unit.
// Holds opcode values, FSM state encoding, ALU function codes, next-PC
// select codes and an opcode classifier used by both the FSM and decoder.
package multi_cycle_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_WB_AL  = 4'd3,
    S_EXE_BR = 4'd4,
    S_EXE_LS = 4'd5,
    S_MEM    = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  typedef enum logic [2:0] {
    C_ALU,
    C_BR,
    C_LS,
    C_JUMP,
    C_HALT,
    C_NOP
  } op_class_t;

  // Unrecognised opcodes fall into C_NOP.
  function automatic op_class_t classify(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI: return C_ALU;
      OP_BEQ:                                         return C_BR;
      OP_LW, OP_SW:                                   return C_LS;
      OP_J:                                           return C_JUMP;
      OP_HALT:                                        return C_HALT;
      default:                                        return C_NOP;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_cu_if.sv
// multi_cycle_cu_if: control bus between the multi-cycle control unit and
// the datapath.
//   op, zero, MemReady        : datapath -> control unit (opcode, ALU zero,
//                               data-memory ready)
//   PCWre .. PCSrc            : control unit -> datapath control signals
//   Halted, State, InsCount   : status/debug outputs of the control unit
// modport master: control-unit side; modport slave: datapath side.
interface multi_cycle_cu_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       op;
  logic             zero;
  logic             MemReady;
  logic             PCWre;
  logic             IRWre;
  logic             InsMenRW;
  logic             ExtSel;
  logic             ALUSrcB;
  logic [2:0]       ALUOp;
  logic             RegOut;
  logic             RegWre;
  logic             ALUM2Reg;
  logic             DataMenRW;
  logic [1:0]       PCSrc;
  logic             Halted;
  logic [3:0]       State;
  logic [CNT_W-1:0] InsCount;

  modport master (
    input  op, zero, MemReady,
    output PCWre, IRWre, InsMenRW, ExtSel, ALUSrcB, ALUOp, RegOut, RegWre,
           ALUM2Reg, DataMenRW, PCSrc, Halted, State, InsCount
  );

  modport slave (
    output op, zero, MemReady,
    input  PCWre, IRWre, InsMenRW, ExtSel, ALUSrcB, ALUOp, RegOut, RegWre,
           ALUM2Reg, DataMenRW, PCSrc, Halted, State, InsCount
  );
endinterface

// File: rtl/multi_cycle_cu_decode.sv
// multi_cycle_decode: purely combinational control-signal decoder.
// Inputs : state (current FSM state), op_q (latched opcode), zero (ALU
//          zero flag), mem_ready (data-memory handshake).
// Outputs: the datapath control signals. Operand/ALU selects depend only
//          on op_q and are held from ID onward; write enables and PC
//          updates are pulsed in the state that commits them.
module multi_cycle_decode
  import multi_cycle_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op_q,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwre,
  output logic       irwre,
  output logic       insmenrw,
  output logic       extsel,
  output logic       alusrcb,
  output logic [2:0] aluop,
  output logic       regout,
  output logic       regwre,
  output logic       alum2reg,
  output logic       datamenrw,
  output logic [1:0] pcsrc
);

  always_comb begin
    pcwre     = 1'b0;
    irwre     = 1'b0;
    insmenrw  = 1'b0;
    extsel    = 1'b0;
    alusrcb   = 1'b0;
    aluop     = ALU_ADD;
    regout    = 1'b0;
    regwre    = 1'b0;
    alum2reg  = 1'b0;
    datamenrw = 1'b0;
    pcsrc     = PC_NEXT;

    // op_q is stale during IF, so the op-derived selects stay at zero there.
    if (state != S_IF) begin
      case (op_q)
        OP_SUB, OP_BEQ: aluop = ALU_SUB;
        OP_OR, OP_ORI:  aluop = ALU_OR;
        OP_AND:         aluop = ALU_AND;
        default:        aluop = ALU_ADD;
      endcase
      alusrcb = op_q inside {OP_ADDI, OP_ORI, OP_LW, OP_SW};
      extsel  = (op_q != OP_ORI);
      regout  = op_q inside {OP_ADD, OP_SUB, OP_OR, OP_AND};
    end

    case (state)
      S_IF: begin
        irwre    = 1'b1;
        insmenrw = 1'b1;
      end
      S_ID: begin
        if (classify(op_q) == C_JUMP) begin
          pcwre = 1'b1;
          pcsrc = PC_JUMP;
        end else if (classify(op_q) == C_NOP) begin
          pcwre = 1'b1;
          pcsrc = PC_NEXT;
        end
      end
      S_EXE_BR: begin
        pcwre = 1'b1;
        pcsrc = zero ? PC_BRANCH : PC_NEXT;
      end
      S_WB_AL: begin
        regwre   = 1'b1;
        alum2reg = 1'b0;
        pcwre    = 1'b1;
        pcsrc    = PC_NEXT;
      end
      S_MEM: begin
        datamenrw = (op_q == OP_SW);
        pcwre     = mem_ready && (op_q == OP_SW);
      end
      S_WB_LD: begin
        regwre   = 1'b1;
        alum2reg = 1'b1;
        pcwre    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_cu.sv
// multi_cycle_cu: multi-cycle control unit sequencing the datapath through
// IF/ID/EXE/MEM/WB phases.
// Ports:
//   CLK   : clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : multi_cycle_cu_if.master (opcode/zero/MemReady in, control,
//           Halted, State and InsCount out)
// The FSM, latched opcode, sticky halt flag and retired-instruction
// counter live here; control-signal decode is in multi_cycle_decode.
module multi_cycle_cu
  import multi_cycle_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  multi_cycle_cu_if.master bus
);

  state_t           state, state_n;
  logic [5:0]       op_q;
  logic             halted;
  logic [CNT_W-1:0] ins_count;
  logic             pc_wre;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IF;
      op_q      <= '0;
      halted    <= 1'b0;
      ins_count <= '0;
    end else begin
      state <= state_n;
      if (state == S_IF) op_q <= bus.op;
      if (state_n == S_HALT) halted <= 1'b1;
      if (pc_wre) ins_count <= ins_count + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IF: state_n = S_ID;
      S_ID: begin
        case (classify(op_q))
          C_ALU:   state_n = S_EXE_AL;
          C_BR:    state_n = S_EXE_BR;
          C_LS:    state_n = S_EXE_LS;
          C_HALT:  state_n = S_HALT;
          default: state_n = S_IF;
        endcase
      end
      S_EXE_AL: state_n = S_WB_AL;
      S_WB_AL:  state_n = S_IF;
      S_EXE_BR: state_n = S_IF;
      S_EXE_LS: state_n = S_MEM;
      S_MEM: begin
        if (bus.MemReady) state_n = (op_q == OP_SW) ? S_IF : S_WB_LD;
      end
      S_WB_LD:  state_n = S_IF;
      S_HALT:   state_n = S_HALT;
      default:  state_n = S_IF;
    endcase
  end

  multi_cycle_decode u_decode (
    .state     (state),
    .op_q      (op_q),
    .zero      (bus.zero),
    .mem_ready (bus.MemReady),
    .pcwre     (pc_wre),
    .irwre     (bus.IRWre),
    .insmenrw  (bus.InsMenRW),
    .extsel    (bus.ExtSel),
    .alusrcb   (bus.ALUSrcB),
    .aluop     (bus.ALUOp),
    .regout    (bus.RegOut),
    .regwre    (bus.RegWre),
    .alum2reg  (bus.ALUM2Reg),
    .datamenrw (bus.DataMenRW),
    .pcsrc     (bus.PCSrc)
  );

  assign bus.PCWre    = pc_wre;
  assign bus.Halted   = halted;
  assign bus.State    = state;
  assign bus.InsCount = ins_count;

endmodule

// File: tb/tb_multi_cycle_cu.sv
module tb_multi_cycle_cu;

  logic CLK;
  logic Reset;
  int   total;
  int   bad;

  multi_cycle_cu_if #(.CNT_W(32)) bus ();

  multi_cycle_cu #(.CNT_W(32)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    Reset = 1'b0;
    #1;
    Reset = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b0; bus.op = 6'b000000; bus.zero = 1'b0; bus.MemReady = 1'b0;
    #2;
    total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL por_state got=%0d exp=0", bus.State); end
    total++; if (bus.IRWre !== 1'b1) begin bad++; $display("FAIL por_irwre got=%b exp=1", bus.IRWre); end
    total++; if (bus.InsMenRW !== 1'b1) begin bad++; $display("FAIL por_insmenrw got=%b exp=1", bus.InsMenRW); end
    total++; if (bus.PCWre !== 1'b0) begin bad++; $display("FAIL por_pcwre got=%b exp=0", bus.PCWre); end
    total++; if (bus.RegWre !== 1'b0) begin bad++; $display("FAIL por_regwre got=%b exp=0", bus.RegWre); end
    total++; if (bus.InsCount !== 32'd0) begin bad++; $display("FAIL por_count got=%0d exp=0", bus.InsCount); end
    total++; if (bus.Halted !== 1'b0) begin bad++; $display("FAIL por_halted got=%b exp=0", bus.Halted); end
    bus.op = 6'b111000;  // J
    Reset = 1'b1;
    tick;
    total++; if (bus.PCSrc !== 2'b11) begin bad++; $display("FAIL rst_j_pcsrc got=%b exp=11", bus.PCSrc); end
    tick;
    total++; if (bus.InsCount !== 32'd1) begin bad++; $display("FAIL rst_j_count got=%0d exp=1", bus.InsCount); end
    bus.op = 6'b000000;  // ADD
    tick;
    tick;
    total++; if (bus.State !== 4'd2) begin bad++; $display("FAIL rst_pre_state got=%0d exp=2", bus.State); end
    Reset = 1'b0;
    #1;
    total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL rst_mid_state got=%0d exp=0", bus.State); end
    total++; if (bus.IRWre !== 1'b1) begin bad++; $display("FAIL rst_mid_irwre got=%b exp=1", bus.IRWre); end
    total++; if (bus.InsCount !== 32'd0) begin bad++; $display("FAIL rst_mid_count got=%0d exp=0", bus.InsCount); end
    total++; if (bus.Halted !== 1'b0) begin bad++; $display("FAIL rst_mid_halted got=%b exp=0", bus.Halted); end
    total++; if (bus.ALUOp !== 3'b000 || bus.RegOut !== 1'b0 || bus.ExtSel !== 1'b0)
      begin bad++; $display("FAIL rst_mid_ctl got=%b/%b/%b exp=000/0/0", bus.ALUOp, bus.RegOut, bus.ExtSel); end
    #1;
    Reset = 1'b1;
    #1;
    total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL rst_rel_state got=%0d exp=0", bus.State); end
    tick;
    total++; if (bus.State !== 4'd1) begin bad++; $display("FAIL rst_rel_id got=%0d exp=1", bus.State); end
  endtask

  task automatic test_add;
    do_reset;
    bus.op = 6'b000000;
    #1;
    total++; if (bus.State !== 4'd0 || bus.IRWre !== 1'b1) begin bad++; $display("FAIL add_if got=%0d/%b exp=0/1", bus.State, bus.IRWre); end
    tick;
    bus.op = 6'b111111;  // must be ignored outside IF
    #1;
    total++; if (bus.State !== 4'd1) begin bad++; $display("FAIL add_id_state got=%0d exp=1", bus.State); end
    total++; if (bus.IRWre !== 1'b0) begin bad++; $display("FAIL add_id_irwre got=%b exp=0", bus.IRWre); end
    total++; if (bus.PCWre !== 1'b0) begin bad++; $display("FAIL add_id_pcwre got=%b exp=0", bus.PCWre); end
    tick;
    total++; if (bus.State !== 4'd2) begin bad++; $display("FAIL add_exe_state got=%0d exp=2", bus.State); end
    total++; if (bus.RegWre !== 1'b0) begin bad++; $display("FAIL add_exe_regwre got=%b exp=0", bus.RegWre); end
    tick;
    total++; if (bus.State !== 4'd3) begin bad++; $display("FAIL add_wb_state got=%0d exp=3", bus.State); end
    total++; if (bus.RegWre !== 1'b1) begin bad++; $display("FAIL add_wb_regwre got=%b exp=1", bus.RegWre); end
    total++; if (bus.RegOut !== 1'b1) begin bad++; $display("FAIL add_wb_regout got=%b exp=1", bus.RegOut); end
    total++; if (bus.ALUOp !== 3'b000) begin bad++; $display("FAIL add_wb_aluop got=%b exp=000", bus.ALUOp); end
    total++; if (bus.PCWre !== 1'b1 || bus.PCSrc !== 2'b00) begin bad++; $display("FAIL add_wb_pc got=%b/%b exp=1/00", bus.PCWre, bus.PCSrc); end
    total++; if (bus.ALUM2Reg !== 1'b0 || bus.ALUSrcB !== 1'b0) begin bad++; $display("FAIL add_wb_mux got=%b/%b exp=0/0", bus.ALUM2Reg, bus.ALUSrcB); end
    total++; if (bus.InsCount !== 32'd0) begin bad++; $display("FAIL add_wb_count got=%0d exp=0", bus.InsCount); end
    tick;
    total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL add_done_state got=%0d exp=0", bus.State); end
    total++; if (bus.InsCount !== 32'd1) begin bad++; $display("FAIL add_done_count got=%0d exp=1", bus.InsCount); end
  endtask

  task automatic test_beq(input logic z, input logic [1:0] exp_src);
    do_reset;
    bus.op = 6'b110000;
    bus.zero = z;
    tick;
    total++; if (bus.State !== 4'd1 || bus.PCWre !== 1'b0) begin bad++; $display("FAIL beq_id got=%0d/%b exp=1/0", bus.State, bus.PCWre); end
    tick;
    total++; if (bus.State !== 4'd4) begin bad++; $display("FAIL beq_exe_state got=%0d exp=4", bus.State); end
    total++; if (bus.PCSrc !== exp_src) begin bad++; $display("FAIL beq_pcsrc z=%b got=%b exp=%b", z, bus.PCSrc, exp_src); end
    total++; if (bus.PCWre !== 1'b1) begin bad++; $display("FAIL beq_pcwre got=%b exp=1", bus.PCWre); end
    total++; if (bus.ALUOp !== 3'b001) begin bad++; $display("FAIL beq_aluop got=%b exp=001", bus.ALUOp); end
    tick;
    total++; if (bus.State !== 4'd0 || bus.InsCount !== 32'd1) begin bad++; $display("FAIL beq_done got=%0d/%0d exp=0/1", bus.State, bus.InsCount); end
    bus.zero = 1'b0;
  endtask

  task automatic test_lw;
    do_reset;
    bus.op = 6'b100111;
    bus.MemReady = 1'b0;
    tick;
    tick;
    total++; if (bus.State !== 4'd5 || bus.ALUSrcB !== 1'b1) begin bad++; $display("FAIL lw_exe got=%0d/%b exp=5/1", bus.State, bus.ALUSrcB); end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (bus.State !== 4'd6 || bus.DataMenRW !== 1'b0 || bus.PCWre !== 1'b0)
        begin bad++; $display("FAIL lw_wait%0d got=%0d/%b/%b exp=6/0/0", i, bus.State, bus.DataMenRW, bus.PCWre); end
    end
    tick;
    bus.MemReady = 1'b1;
    #1;
    total++; if (bus.State !== 4'd6 || bus.PCWre !== 1'b0) begin bad++; $display("FAIL lw_ready got=%0d/%b exp=6/0", bus.State, bus.PCWre); end
    tick;
    bus.MemReady = 1'b0;
    #1;
    total++; if (bus.State !== 4'd7) begin bad++; $display("FAIL lw_wb_state got=%0d exp=7", bus.State); end
    total++; if (bus.RegWre !== 1'b1 || bus.ALUM2Reg !== 1'b1) begin bad++; $display("FAIL lw_wb_reg got=%b/%b exp=1/1", bus.RegWre, bus.ALUM2Reg); end
    total++; if (bus.RegOut !== 1'b0 || bus.PCWre !== 1'b1) begin bad++; $display("FAIL lw_wb_ctl got=%b/%b exp=0/1", bus.RegOut, bus.PCWre); end
    tick;
    total++; if (bus.State !== 4'd0 || bus.InsCount !== 32'd1) begin bad++; $display("FAIL lw_done got=%0d/%0d exp=0/1", bus.State, bus.InsCount); end
  endtask

  task automatic test_sw;
    logic regw_seen;
    do_reset;
    regw_seen = 1'b0;
    bus.op = 6'b100110;
    bus.MemReady = 1'b0;
    regw_seen = regw_seen | bus.RegWre;
    tick; regw_seen = regw_seen | bus.RegWre;
    tick; regw_seen = regw_seen | bus.RegWre;
    for (int i = 0; i < 2; i++) begin
      tick;
      regw_seen = regw_seen | bus.RegWre;
      total++; if (bus.State !== 4'd6 || bus.DataMenRW !== 1'b1 || bus.PCWre !== 1'b0)
        begin bad++; $display("FAIL sw_wait%0d got=%0d/%b/%b exp=6/1/0", i, bus.State, bus.DataMenRW, bus.PCWre); end
      total++; if (bus.ALUSrcB !== 1'b1 || bus.ExtSel !== 1'b1)
        begin bad++; $display("FAIL sw_sel%0d got=%b/%b exp=1/1", i, bus.ALUSrcB, bus.ExtSel); end
    end
    bus.MemReady = 1'b1;
    #1;
    regw_seen = regw_seen | bus.RegWre;
    total++; if (bus.PCWre !== 1'b1 || bus.DataMenRW !== 1'b1) begin bad++; $display("FAIL sw_ready got=%b/%b exp=1/1", bus.PCWre, bus.DataMenRW); end
    tick;
    bus.MemReady = 1'b0;
    regw_seen = regw_seen | bus.RegWre;
    total++; if (bus.State !== 4'd0 || bus.InsCount !== 32'd1) begin bad++; $display("FAIL sw_done got=%0d/%0d exp=0/1", bus.State, bus.InsCount); end
    total++; if (regw_seen !== 1'b0) begin bad++; $display("FAIL sw_regwre got=%b exp=0", regw_seen); end
  endtask

  task automatic test_nop;
    do_reset;
    bus.op = 6'b000011;
    tick;
    total++; if (bus.State !== 4'd1 || bus.PCWre !== 1'b1 || bus.PCSrc !== 2'b00)
      begin bad++; $display("FAIL nop_id got=%0d/%b/%b exp=1/1/00", bus.State, bus.PCWre, bus.PCSrc); end
    tick;
    total++; if (bus.State !== 4'd0 || bus.InsCount !== 32'd1) begin bad++; $display("FAIL nop_done got=%0d/%0d exp=0/1", bus.State, bus.InsCount); end
  endtask

  task automatic test_j_ori_halt;
    do_reset;
    bus.op = 6'b111000;
    tick;
    total++; if (bus.PCSrc !== 2'b11 || bus.PCWre !== 1'b1) begin bad++; $display("FAIL j_id got=%b/%b exp=11/1", bus.PCSrc, bus.PCWre); end
    tick;
    bus.op = 6'b010010;  // ORI
    tick;
    total++; if (bus.ExtSel !== 1'b0) begin bad++; $display("FAIL ori_extsel got=%b exp=0", bus.ExtSel); end
    total++; if (bus.ALUOp !== 3'b011) begin bad++; $display("FAIL ori_aluop got=%b exp=011", bus.ALUOp); end
    total++; if (bus.RegOut !== 1'b0 || bus.ALUSrcB !== 1'b1) begin bad++; $display("FAIL ori_sel got=%b/%b exp=0/1", bus.RegOut, bus.ALUSrcB); end
    tick;
    tick;
    total++; if (bus.State !== 4'd3 || bus.RegWre !== 1'b1) begin bad++; $display("FAIL ori_wb got=%0d/%b exp=3/1", bus.State, bus.RegWre); end
    tick;
    bus.op = 6'b111111;  // HALT
    tick;
    total++; if (bus.State !== 4'd1 || bus.PCWre !== 1'b0 || bus.Halted !== 1'b0)
      begin bad++; $display("FAIL halt_id got=%0d/%b/%b exp=1/0/0", bus.State, bus.PCWre, bus.Halted); end
    tick;
    total++; if (bus.State !== 4'd8) begin bad++; $display("FAIL halt_state got=%0d exp=8", bus.State); end
    total++; if (bus.Halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", bus.Halted); end
    total++; if (bus.InsCount !== 32'd2) begin bad++; $display("FAIL halt_count got=%0d exp=2", bus.InsCount); end
    for (int i = 0; i < 20; i++) begin
      bus.op = 6'(i * 7);
      bus.zero = i[0];
      bus.MemReady = i[1];
      tick;
      total++; if (bus.State !== 4'd8 || bus.InsCount !== 32'd2 || bus.Halted !== 1'b1)
        begin bad++; $display("FAIL halt_hold%0d got=%0d/%0d/%b exp=8/2/1", i, bus.State, bus.InsCount, bus.Halted); end
      total++; if (bus.PCWre !== 1'b0 || bus.RegWre !== 1'b0)
        begin bad++; $display("FAIL halt_quiet%0d got=%b/%b exp=0/0", i, bus.PCWre, bus.RegWre); end
    end
    bus.zero = 1'b0;
    bus.MemReady = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_add;
    test_beq(1'b1, 2'b01);
    test_beq(1'b0, 2'b00);
    test_lw;
    test_sw;
    test_nop;
    test_j_ori_halt;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
